// File: rtl/mcu_fetch_pkg.sv
// ============================================================================
//  Module      : mcu_fetch_pkg
//  Description : Shared types and constants for the MCU instruction fetch
//                path (program ROM geometry, reset vector, bubble word,
//                fetch FSM states and per-cycle fetch action arbitration).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcu_fetch_pkg;

   // Program ROM geometry shared with the ROM and the decoder
   localparam int              FETCH_ADDR_W      = 11;
   localparam int              FETCH_DATA_W      = 14;
   localparam int              FETCH_STACK_DEPTH = 8;
   localparam logic [10:0]     FETCH_RESET_VEC   = 11'h000;
   localparam logic [13:0]     FETCH_NOP_WORD    = 14'h0000;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_t;

   // What the fetch unit does in a given cycle, after priority resolution
   typedef enum logic [2:0] {
      ACT_HOLD = 3'd0,
      ACT_RET  = 3'd1,
      ACT_CALL = 3'd2,
      ACT_JUMP = 3'd3,
      ACT_SKIP = 3'd4,
      ACT_SEQ  = 3'd5
   } fetch_act_t;

   // Resolve the request lines into one action: stall > ret > call > jump > skip
   function automatic fetch_act_t fetch_arbitrate(
      input logic stall,
      input logic ret,
      input logic call,
      input logic jump,
      input logic skip
   );
      fetch_act_t act;
      if (stall)      act = ACT_HOLD;
      else if (ret)   act = ACT_RET;
      else if (call)  act = ACT_CALL;
      else if (jump)  act = ACT_JUMP;
      else if (skip)  act = ACT_SKIP;
      else            act = ACT_SEQ;
      return act;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ret_stack.sv
// ============================================================================
//  Module      : fetch_ret_stack
//  Description : Circular return-address stack. A push when full overwrites
//                the oldest entry, a pop when empty returns the wrapped entry;
//                either sets a sticky overflow flag. Reset clears only the
//                pointer, fill count and flag, never the stored addresses.
//                Used by instr_fetch_ctrl when FETCH_STACK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ret_stack #(
   parameter int ADDR_W = mcu_fetch_pkg::FETCH_ADDR_W,
   parameter int DEPTH  = mcu_fetch_pkg::FETCH_STACK_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              ovf_o
);

   localparam int               c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(DEPTH);

   logic [ADDR_W-1:0]  mem_q [DEPTH];
   logic [c_ptr_w-1:0] ptr_q, ptr_d;
   logic [c_ptr_w:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [c_ptr_w-1:0] w_top_idx;

   // ptr_q is the next free slot; the top entry sits just below it (mod DEPTH)
   assign w_top_idx = ptr_q - c_ptr_w'(1);
   assign top_o     = mem_q[w_top_idx];
   assign ovf_o     = ovf_q;

   // Pointer / fill count / sticky overflow next-state
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push_i) begin
         ptr_d = ptr_q + c_ptr_w'(1);
         if (cnt_q == c_full) ovf_d = 1'b1;
         else                 cnt_d = cnt_q + (c_ptr_w + 1)'(1);
      end else if (pop_i) begin
         ptr_d = w_top_idx;
         if (cnt_q == '0) ovf_d = 1'b1;
         else             cnt_d = cnt_q - (c_ptr_w + 1)'(1);
      end
   end

   // Control registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Entry storage, deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (push_i) mem_q[ptr_q] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Program-ROM fetch sequencer. Owns the PC, drives the ROM
//                address and registers the returned word into the IR with
//                its fetch address and a valid flag. Handles stall, jump,
//                call/return and skip requests from decode/execute.
//                Build option: define FETCH_STACK_EN to include the return
//                stack; otherwise call acts as jump, return is ignored and
//                stack_ovf_o is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
   import mcu_fetch_pkg::*;
#(
   parameter int                ADDR_W      = FETCH_ADDR_W,
   parameter int                DATA_W      = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_VEC   = FETCH_RESET_VEC,
   parameter int                STACK_DEPTH = FETCH_STACK_DEPTH,
   parameter logic [DATA_W-1:0] NOP_WORD    = FETCH_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   input  logic              stall_i,
   input  logic              jump_en_i,
   input  logic              call_en_i,
   input  logic              ret_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              skip_i,
   output logic [DATA_W-1:0] ir_o,
   output logic [ADDR_W-1:0] ir_pc_o,
   output logic              ir_valid_o,
   output logic              stack_ovf_o
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;

   fetch_act_t        w_act;
   logic              w_ret_req;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_stack_top;

`ifdef FETCH_STACK_EN
   assign w_ret_req = ret_en_i;

   fetch_ret_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_ret_stack (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (w_push),
      .pop_i       (w_pop),
      .push_data_i (pc_q),
      .top_o       (w_stack_top),
      .ovf_o       (stack_ovf_o)
   );
`else
   // Without a stack a return has nowhere to go: drop it and fetch normally
   logic w_unused_cfg;
   assign w_ret_req    = 1'b0;
   assign w_stack_top  = '0;
   assign stack_ovf_o  = 1'b0;
   assign w_unused_cfg = ret_en_i ^ w_push ^ w_pop ^ STACK_DEPTH[0];
`endif

   assign w_act = fetch_arbitrate(stall_i, w_ret_req, call_en_i, jump_en_i, skip_i);

   // ROM is combinational, so the address is simply the PC register
   assign rom_addr_o  = pc_q;
   assign ir_o        = ir_q;
   assign ir_pc_o     = ir_pc_q;
   assign ir_valid_o  = ir_valid_q;

   // Next-state for PC, IR and FSM from the arbitrated action
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      case (w_act)
         ACT_RET: begin
            pc_d       = w_stack_top;
            w_pop      = 1'b1;
            ir_d       = NOP_WORD;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b0;
            state_d    = S_FLUSH;
         end
         ACT_CALL: begin
            // pc_q already points past the CALL, so it is the return address
            pc_d       = jump_addr_i;
            w_push     = 1'b1;
            ir_d       = NOP_WORD;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b0;
            state_d    = S_FLUSH;
         end
         ACT_JUMP: begin
            pc_d       = jump_addr_i;
            ir_d       = NOP_WORD;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b0;
            state_d    = S_FLUSH;
         end
         ACT_SKIP: begin
            pc_d       = pc_q + ADDR_W'(1);
            ir_d       = NOP_WORD;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b0;
            state_d    = S_RUN;
         end
         ACT_SEQ: begin
            // Covers boot, run and the cycle leaving a flush alike
            pc_d       = pc_q + ADDR_W'(1);
            ir_d       = rom_data_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            state_d    = S_RUN;
         end
         default: begin
            // Stall: everything holds
         end
      endcase
   end

   // Fetch state registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_VEC;
         ir_q       <= NOP_WORD;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Self-checking bench for instr_fetch_ctrl: directed fetch,
//                redirect, stall, skip, wrap and reset scenarios followed by
//                randomized request traffic, all compared against a
//                behavioural fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

   localparam int AW = 11;
   localparam int DW = 14;
   localparam logic [DW-1:0] NOP = 14'h0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          stall, jump_en, call_en, ret_en, skip;
   logic [AW-1:0] jump_addr;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          stack_ovf;

   logic [DW-1:0] rom [2048];
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rom_addr_o  (rom_addr),
      .rom_data_i  (rom_data),
      .stall_i     (stall),
      .jump_en_i   (jump_en),
      .call_en_i   (call_en),
      .ret_en_i    (ret_en),
      .jump_addr_i (jump_addr),
      .skip_i      (skip),
      .ir_o        (ir),
      .ir_pc_o     (ir_pc),
      .ir_valid_o  (ir_valid),
      .stack_ovf_o (stack_ovf)
   );

   // ---------------- reference model ----------------
   logic [AW-1:0] m_pc, m_ir_pc;
   logic [DW-1:0] m_ir;
   logic          m_valid, m_ovf, m_pc_known;
   logic [AW-1:0] m_stk [8];
   bit            m_stk_written [8];
   int            m_top, m_depth;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic model_reset();
      m_pc = '0; m_ir = NOP; m_ir_pc = '0; m_valid = 1'b0; m_ovf = 1'b0;
      m_pc_known = 1'b1; m_top = 0; m_depth = 0;
   endtask

   task automatic model_bubble();
      m_ir = NOP; m_valid = 1'b0; m_pc_known = 1'b0;
   endtask

   // One clock edge of the fetch unit, written directly from the priority rules
   task automatic model_step(input logic s, input logic j, input logic c, input logic r,
                             input logic k, input logic [AW-1:0] a);
      if (s) return;
`ifndef FETCH_STACK_EN
      r = 1'b0;
      if (c) begin j = 1'b1; c = 1'b0; end
`endif
      if (r) begin
         m_top = (m_top + 7) % 8;
         m_pc  = m_stk[m_top];
         if (m_depth == 0) m_ovf = 1'b1; else m_depth--;
         model_bubble();
      end else if (c) begin
         m_stk[m_top] = m_pc;
         m_stk_written[m_top] = 1'b1;
         m_top = (m_top + 1) % 8;
         if (m_depth == 8) m_ovf = 1'b1; else m_depth++;
         m_pc = a;
         model_bubble();
      end else if (j) begin
         m_pc = a;
         model_bubble();
      end else if (k) begin
         m_ir = NOP; m_ir_pc = m_pc; m_valid = 1'b0; m_pc_known = 1'b1;
         m_pc = m_pc + 1'b1;
      end else begin
         m_ir = rom[m_pc]; m_ir_pc = m_pc; m_valid = 1'b1; m_pc_known = 1'b1;
         m_pc = m_pc + 1'b1;
      end
   endtask

   task automatic compare_all();
      check_val("rom_addr", 32'(rom_addr), 32'(m_pc));
      check_val("ir", 32'(ir), 32'(m_ir));
      check_val("ir_valid", 32'(ir_valid), 32'(m_valid));
      check_val("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
      if (m_pc_known) check_val("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
   endtask

   // Called ~1 time unit after a rising edge: drive, take the next edge, check
   task automatic cycle(input logic s, input logic j, input logic c, input logic r,
                        input logic k, input logic [AW-1:0] a);
      stall = s; jump_en = j; call_en = c; ret_en = r; skip = k; jump_addr = a;
      @(posedge clk);
      cyc++;
      model_step(s, j, c, r, k, a);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic go(input logic [AW-1:0] a);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
   endtask

   // Mid-cycle asynchronous reset pulse, checked before the next edge
   task automatic async_reset_pulse();
      #2;
      rst_n = 1'b0;
      stall = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; skip = 1'b0;
      #1;
      model_reset();
      compare_all();
      #1;
      rst_n = 1'b1;
   endtask

   // Watchdog: the run is cycle-driven, this only guards against a stuck sim
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic s, j, c, r, k;
      logic [AW-1:0] a;

      for (int i = 0; i < 2048; i++) rom[i] = DW'($urandom);
      rom[0] = 14'h3044;
      rom[1] = 14'h3E01;
      rom[2] = 14'h3E02;
      for (int i = 0; i < 8; i++) begin m_stk[i] = '0; m_stk_written[i] = 1'b0; end
      stall = 0; jump_en = 0; call_en = 0; ret_en = 0; skip = 0; jump_addr = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Sequential fetch from the reset vector: 3044 @0, 3E01 @1, 3E02 @2
      idle(3);
      // Jump to 005 with PC at 003: one bubble then the target word
      go(11'h005);
      idle(2);
      // Stall three cycles at PC=004 with a jump requested: jump is dropped
      go(11'h004);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h200);
      idle(2);
      // Skip at PC=002, then word @003
      go(11'h002);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      idle(2);
      // Wrap from 7FF to 000
      go(11'h7FF);
      idle(3);
      // Call (acts as jump when the stack is absent) and return
      go(11'h010);
      idle(1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h100);
      idle(2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      idle(2);
`ifdef FETCH_STACK_EN
      // Nine nested calls on an eight-deep stack, then nine returns
      for (int n = 0; n < 9; n++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AW'(11'h200 + n * 16));
         idle(1);
      end
      for (int n = 0; n < 9; n++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
         idle(1);
      end
`endif
      // Asynchronous reset in the middle of operation
      idle(1);
      async_reset_pulse();
      idle(3);

      // Randomized request traffic
      for (int n = 0; n < 600; n++) begin
         s = ($urandom % 6) == 0;
         r = ($urandom % 9) == 0;
         c = ($urandom % 9) == 0;
         j = ($urandom % 8) == 0;
         k = ($urandom % 6) == 0;
         a = AW'($urandom);
`ifdef FETCH_STACK_EN
         if (r && !m_stk_written[(m_top + 7) % 8]) r = 1'b0;
`endif
         cycle(s, j, c, r, k, a);
         if (n == 300) async_reset_pulse();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
